// File: rtl/mem_access_controller.sv
// Load/store controller for the single-port 64-bit DataMemory: sized accesses,
// little-endian lane extraction with sign/zero extension, and read-modify-write stores.
module mem_access_controller #(
    parameter int MEM_WORDS = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddr,
    input  logic [63:0] ReqWData,
    output logic        RespValid,
    output logic [63:0] RespData,
    output logic        RespError,
    output logic [63:0] Address,
    output logic [63:0] WriteData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [63:0] ReadData,
    output logic [2:0]  DebugState
);

    // Handshake: a request is taken on a posedge where ReqValid && ReqReady;
    // RespValid is a single-cycle pulse with no backpressure.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_CAP      = 3'd2,
        S_WR       = 3'd3,
        S_RESP_ERR = 3'd4
    } state_t;

    state_t      state, state_n;
    logic        req_write, req_write_n;
    logic [1:0]  req_size, req_size_n;
    logic        req_signed, req_signed_n;
    logic [2:0]  req_offset, req_offset_n;
    logic [63:0] req_wdata, req_wdata_n;
    logic        resp_valid_n, resp_error_n, mem_read_n, mem_write_n;
    logic [63:0] resp_data_n, address_n, write_data_n;
    logic        accept, misaligned, out_of_range;
    logic [2:0]  align_mask;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] data, input logic [2:0] offset,
                                            input logic [1:0] size, input logic sgn);
        logic [63:0] shifted;
        shifted = data >> {offset, 3'b000};
        case (size)
            2'd0:    extract = sgn ? {{56{shifted[7]}}, shifted[7:0]}   : {56'd0, shifted[7:0]};
            2'd1:    extract = sgn ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            2'd2:    extract = sgn ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default: extract = shifted;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] data, input logic [63:0] wdata,
                                          input logic [2:0] offset, input logic [1:0] size);
        logic [63:0] lane_mask;
        lane_mask = size_mask(size) << {offset, 3'b000};
        merge = (data & ~lane_mask) | ((wdata & size_mask(size)) << {offset, 3'b000});
    endfunction

    always_comb begin
        case (ReqSize)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign ReqReady     = (state == S_IDLE);
    assign DebugState   = state;
    assign accept       = ReqValid && ReqReady;
    assign misaligned   = |(ReqAddr[2:0] & align_mask);
    assign out_of_range = (ReqAddr >> 3) >= 64'(MEM_WORDS);

    always_comb begin
        state_n      = state;
        req_write_n  = req_write;
        req_size_n   = req_size;
        req_signed_n = req_signed;
        req_offset_n = req_offset;
        req_wdata_n  = req_wdata;
        address_n    = Address;
        write_data_n = WriteData;
        resp_valid_n = 1'b0;
        resp_error_n = 1'b0;
        resp_data_n  = 64'd0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    req_write_n  = ReqWrite;
                    req_size_n   = ReqSize;
                    req_signed_n = ReqSigned;
                    req_offset_n = ReqAddr[2:0];
                    req_wdata_n  = ReqWData;
                    address_n    = ReqAddr >> 3;
                    if (misaligned || out_of_range) begin
                        state_n = S_RESP_ERR;
                    end else if (ReqWrite && ReqSize == 2'd3) begin
                        write_data_n = ReqWData;
                        mem_write_n  = 1'b1;
                        state_n      = S_WR;
                    end else begin
                        mem_read_n = 1'b1;
                        state_n    = S_RD;
                    end
                end
            end
            S_RD: state_n = S_CAP;
            S_CAP: begin
                // ReadData is valid here; stores merge into it, loads return from it.
                if (req_write) begin
                    write_data_n = merge(ReadData, req_wdata, req_offset, req_size);
                    mem_write_n  = 1'b1;
                    state_n      = S_WR;
                end else begin
                    resp_valid_n = 1'b1;
                    resp_data_n  = extract(ReadData, req_offset, req_size, req_signed);
                    state_n      = S_IDLE;
                end
            end
            S_WR: begin
                resp_valid_n = 1'b1;
                state_n      = S_IDLE;
            end
            S_RESP_ERR: begin
                resp_valid_n = 1'b1;
                resp_error_n = 1'b1;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            req_write   <= 1'b0;
            req_size    <= 2'd0;
            req_signed  <= 1'b0;
            req_offset  <= 3'd0;
            req_wdata   <= 64'd0;
            Address     <= 64'd0;
            WriteData   <= 64'd0;
            RespValid   <= 1'b0;
            RespError   <= 1'b0;
            RespData    <= 64'd0;
            MemoryRead  <= 1'b0;
            MemoryWrite <= 1'b0;
        end else begin
            state       <= state_n;
            req_write   <= req_write_n;
            req_size    <= req_size_n;
            req_signed  <= req_signed_n;
            req_offset  <= req_offset_n;
            req_wdata   <= req_wdata_n;
            Address     <= address_n;
            WriteData   <= write_data_n;
            RespValid   <= resp_valid_n;
            RespError   <= resp_error_n;
            RespData    <= resp_data_n;
            MemoryRead  <= mem_read_n;
            MemoryWrite <= mem_write_n;
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller with a behavioural DataMemory model and a
// response scoreboard that checks data, error flag and response cycle.
module tb_mem_access_controller;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
    logic [1:0]  ReqSize;
    logic [63:0] ReqAddr, ReqWData;
    logic        RespValid, RespError;
    logic [63:0] RespData, Address, WriteData, ReadData;
    logic        MemoryRead, MemoryWrite;
    logic [2:0]  DebugState;

    logic [63:0] mem [0:63];
    logic [64:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          rd_cycles = 0, wr_cycles = 0, overlap = 0;
    logic [63:0] last_wr_addr = 64'd0;
    int          waits;

    mem_access_controller #(.MEM_WORDS(64)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData), .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
        .Address(Address), .WriteData(WriteData), .MemoryRead(MemoryRead),
        .MemoryWrite(MemoryWrite), .ReadData(ReadData), .DebugState(DebugState)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // DataMemory model: writes on negedge, registered reads on posedge.
    always @(negedge Clock) if (MemoryWrite) mem[Address[5:0]] = WriteData;
    always @(posedge Clock) if (MemoryRead) ReadData <= mem[Address[5:0]];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: strobe accounting and scoreboard pop on every response pulse.
    always @(negedge Clock) begin
        logic [64:0] e;
        int          ec;
        if (MemoryRead) rd_cycles++;
        if (MemoryWrite) begin
            wr_cycles++;
            last_wr_addr = Address;
        end
        if (MemoryRead && MemoryWrite) overlap++;
        if (RespValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h required=none", {RespError, RespData});
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("resp", {RespError, RespData}, e);
                check("resp_cycle", 65'(cyc), 65'(ec));
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic exp_err, input logic [63:0] exp_data, input int lat,
                          input bit expect_resp, input bit hold, output int nwait);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqSize  = sz;
        ReqSigned = sg;
        ReqAddr  = addr;
        ReqWData = wdata;
        nwait = 0;
        while (!ReqReady && nwait < 20) begin
            @(negedge Clock);
            nwait++;
        end
        if (!ReqReady) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
            ReqValid = 1'b0;
            return;
        end
        if (expect_resp) begin
            exp_q.push_back({exp_err, exp_data});
            exp_cyc_q.push_back(cyc + 1 + lat);
        end
        @(posedge Clock);
        @(negedge Clock);
        if (!hold) ReqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge Clock);
    endtask

    task automatic clear_counts();
        rd_cycles = 0;
        wr_cycles = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        Reset = 1'b1;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddr = 64'd0; ReqWData = 64'd0;
        repeat (2) @(negedge Clock);
        check("rst_ready", 65'(ReqReady), 65'd1);
        check("rst_state", 65'(DebugState), 65'd0);
        check("rst_resp", {RespError, RespData}, 65'd0);
        check("rst_respvalid", 65'(RespValid), 65'd0);
        check("rst_addr_wdata", 65'(Address | WriteData), 65'd0);
        check("rst_strobes", 65'({MemoryRead, MemoryWrite}), 65'd0);
        Reset = 1'b0;
        @(negedge Clock);

        // Double store then double load.
        clear_counts();
        do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0, 1, 1, 0, waits);
        wait_idle();
        check("dstore_wr_cycles", 65'(wr_cycles), 65'd1);
        check("dstore_rd_cycles", 65'(rd_cycles), 65'd0);
        check("dstore_addr", 65'(last_wr_addr), 65'd3);
        do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 1'b0, 64'hDEADBEEF_CAFEF00D, 2, 1, 0, waits);
        wait_idle();

        // Sub-word load extension.
        do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h0000F080, 1'b0, 64'd0, 1, 1, 0, waits);
        do_req(1'b0, 2'd0, 1'b1, 64'h18, 64'd0, 1'b0, 64'hFFFFFFFF_FFFFFF80, 2, 1, 0, waits);
        do_req(1'b0, 2'd0, 1'b0, 64'h18, 64'd0, 1'b0, 64'h80, 2, 1, 0, waits);
        do_req(1'b0, 2'd1, 1'b1, 64'h18, 64'd0, 1'b0, 64'hFFFFFFFF_FFFFF080, 2, 1, 0, waits);
        do_req(1'b0, 2'd0, 1'b0, 64'h19, 64'd0, 1'b0, 64'hF0, 2, 1, 0, waits);
        do_req(1'b0, 2'd2, 1'b1, 64'h18, 64'd0, 1'b0, 64'hF080, 2, 1, 0, waits);
        wait_idle();

        // Read-modify-write stores.
        mem[5] = 64'h11223344_55667788;
        clear_counts();
        do_req(1'b1, 2'd0, 1'b0, 64'h2D, 64'hFFFFFFFF_FFFFFFAB, 1'b0, 64'd0, 3, 1, 0, waits);
        wait_idle();
        check("rmw_byte_mem", 65'(mem[5]), 65'h1122AB44_55667788);
        check("rmw_rd_cycles", 65'(rd_cycles), 65'd1);
        check("rmw_wr_cycles", 65'(wr_cycles), 65'd1);
        do_req(1'b1, 2'd1, 1'b0, 64'h2A, 64'h0000BEEF, 1'b0, 64'd0, 3, 1, 0, waits);
        wait_idle();
        check("rmw_half_mem", 65'(mem[5]), 65'h1122AB44_BEEF7788);
        do_req(1'b0, 2'd2, 1'b1, 64'h28, 64'd0, 1'b0, 64'hFFFFFFFF_BEEF7788, 2, 1, 0, waits);
        do_req(1'b0, 2'd2, 1'b1, 64'h2C, 64'd0, 1'b0, 64'h1122AB44, 2, 1, 0, waits);
        wait_idle();

        // Errors: misaligned and out of range never strobe memory.
        clear_counts();
        do_req(1'b0, 2'd2, 1'b0, 64'h1A, 64'd0, 1'b1, 64'd0, 1, 1, 0, waits);
        do_req(1'b1, 2'd3, 1'b0, 64'h200, 64'h1234, 1'b1, 64'd0, 1, 1, 0, waits);
        do_req(1'b1, 2'd1, 1'b0, 64'h1F, 64'h1234, 1'b1, 64'd0, 1, 1, 0, waits);
        wait_idle();
        check("err_rd_cycles", 65'(rd_cycles), 65'd0);
        check("err_wr_cycles", 65'(wr_cycles), 65'd0);
        mem[63] = 64'hA500_0000_0000_0000;
        do_req(1'b0, 2'd0, 1'b0, 64'h1FF, 64'd0, 1'b0, 64'hA5, 2, 1, 0, waits);
        wait_idle();

        // Back-to-back loads with ReqValid held high.
        overlap = 0;
        do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 1'b0, 64'hF080, 2, 1, 1, waits);
        do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'd0, 1'b0, 64'h1122AB44_BEEF7788, 2, 1, 1, waits);
        check("b2b_wait_2", 65'(waits), 65'd2);
        do_req(1'b0, 2'd0, 1'b0, 64'h2F, 64'd0, 1'b0, 64'h11, 2, 1, 1, waits);
        check("b2b_wait_3", 65'(waits), 65'd2);
        do_req(1'b0, 2'd1, 1'b1, 64'h2E, 64'd0, 1'b0, 64'h1122, 2, 1, 0, waits);
        check("b2b_wait_4", 65'(waits), 65'd2);
        wait_idle();
        check("strobe_overlap", 65'(overlap), 65'd0);

        // Reset during CAP of a byte store drops the request.
        mem[7] = 64'h01234567_89ABCDEF;
        do_req(1'b1, 2'd0, 1'b0, 64'h38, 64'h77, 1'b0, 64'd0, 3, 0, 0, waits);
        @(negedge Clock);
        check("mid_state_cap", 65'(DebugState), 65'd2);
        clear_counts();
        Reset = 1'b1;
        #1;
        check("mid_rst_ready", 65'(ReqReady), 65'd1);
        check("mid_rst_strobes", 65'({MemoryRead, MemoryWrite, RespValid, RespError}), 65'd0);
        check("mid_rst_addr", 65'(Address), 65'd0);
        check("mid_rst_wdata", 65'(WriteData), 65'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("mid_rst_mem", 65'(mem[7]), 65'h01234567_89ABCDEF);
        check("mid_rst_wr_cycles", 65'(wr_cycles), 65'd0);
        do_req(1'b0, 2'd3, 1'b0, 64'h38, 64'd0, 1'b0, 64'h01234567_89ABCDEF, 2, 1, 0, waits);
        do_req(1'b1, 2'd0, 1'b0, 64'h38, 64'h55, 1'b0, 64'd0, 3, 1, 0, waits);
        do_req(1'b0, 2'd3, 1'b0, 64'h38, 64'd0, 1'b0, 64'h01234567_89ABCD55, 2, 1, 0, waits);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
